mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter RD_LAT, default 1, SHALL be the memory read latency in cycles from the issue cycle (legal 1..3).
REQ-002 Parameter AW, default 16, SHALL be the address width; parameter DW, default 16, SHALL be the data width.
REQ-003 Ports SHALL be, one per line, name direction width meaning:
 CLK  input  1  system clock, rising edge
 Reset  input  1  asynchronous, active-low reset
 cpu_req  input  1  processor access request (fetch or data)
 cpu_we  input  1  1 = write, 0 = read
 cpu_addr  input  AW  processor address
 cpu_wdata  input  DW  processor write data
 cpu_ack  output  1  one-cycle completion pulse to processor
 ld_req  input  1  loader/debug access request
 ld_we  input  1  1 = write, 0 = read
 ld_addr  input  AW  loader address
 ld_wdata  input  DW  loader write data
 ld_ack  output  1  one-cycle completion pulse to loader
 ld_lock  input  1  loader-exclusive mode; processor not granted
 rdata  output  DW  registered read data, valid with ack
 mem_en  output  1  memory access strobe
 mem_we  output  1  memory write enable
 mem_addr  output  AW  memory address
 mem_wdata  output  DW  memory write data
 mem_rdata  input  DW  memory read data
 busy  output  1  transaction in progress (state != IDLE)
 grant_id  output  1  port owning current transaction (0 = cpu, 1 = loader)

Function
REQ-004 FSM states SHALL be IDLE, ISSUE, WAIT, RESP.
REQ-005 IDLE: if an eligible request exists, the arbiter SHALL select a port, latch its we/addr/wdata, set grant_id, and go to ISSUE; otherwise remain in IDLE.
REQ-006 Eligibility: cpu_req is eligible only when ld_lock = 0; ld_req is always eligible.
REQ-007 Both eligible: grant SHALL go to the port opposite last_grant (round-robin); last_grant SHALL update on every grant.
REQ-008 ISSUE: mem_en = 1, mem_we/mem_addr/mem_wdata = latched values for exactly one cycle; write goes to RESP, read goes to WAIT.
REQ-009 WAIT: lasts exactly RD_LAT cycles via a down-counter; on the final WAIT edge mem_rdata SHALL be captured into rdata; next state RESP.
REQ-010 RESP: ack of the granted port SHALL be 1 for exactly one cycle, the other ack 0; next state IDLE.
REQ-011 Latency: request sampled in IDLE at edge N -> write ack high in cycle N+2, read ack high in cycle N+2+RD_LAT.
REQ-012 Requesters SHALL hold req and operands until ack; latched operands make mid-transaction operand changes or req deassertion ineffective; the transaction completes and ack is still issued.
REQ-013 Back-to-back: a req still high in the IDLE cycle after RESP SHALL be treated as a new request.
REQ-014 ld_lock asserted mid-processor-transaction SHALL NOT abort it; it affects the next arbitration only.
REQ-015 rdata SHALL hold its value until the next read capture; writes SHALL NOT change rdata.
REQ-016 mem_en and mem_we SHALL be 0 in all states except ISSUE.
REQ-017 busy SHALL be 1 in ISSUE, WAIT and RESP.

Reset
REQ-018 Reset low SHALL immediately force IDLE, mem_en = 0, mem_we = 0, cpu_ack = 0, ld_ack = 0, busy = 0, grant_id = 0, rdata = 0, mem_addr = 0, mem_wdata = 0, WAIT counter = 0, last_grant = 1, so the processor wins the first tie.
REQ-019 Reset asserted mid-transaction SHALL abandon it without ack; operation resumes from IDLE on the first edge after Reset returns high.

Verification
REQ-020 RD_LAT = 1, cpu read addr 0x0010, memory returns 0xBEEF -> mem_en one cycle with addr 0x0010, cpu_ack in cycle N+3, rdata = 0xBEEF.
REQ-021 ld write addr 0x0004 data 0x1234 -> mem_en = mem_we = 1 one cycle, ld_ack in cycle N+2, rdata unchanged.
REQ-022 cpu_req and ld_req held continuously after reset -> grants alternate cpu, ld, cpu, ld; no port acked twice in succession.
REQ-023 ld_lock = 1 with both requesting -> only ld_ack pulses; cpu_ack appears within 4+RD_LAT cycles of ld_lock falling.
REQ-024 RD_LAT = 3, Reset pulsed low during WAIT -> no ack, mem_en = 0 immediately, busy = 0; next request completes normally.
REQ-025 cpu_addr changed from 0x0010 to 0x0020 during WAIT -> memory accessed only at 0x0010, ack still issued.

Source files
------------

// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin arbiter giving a processor port and a loader port
// single-transaction access to a fixed-latency synchronous memory.
module mem_arbiter #(
    parameter int RD_LAT = 1,
    parameter int AW     = 16,
    parameter int DW     = 16
) (
    input  logic          CLK,
    input  logic          Reset,
    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_wdata,
    output logic          cpu_ack,
    input  logic          ld_req,
    input  logic          ld_we,
    input  logic [AW-1:0] ld_addr,
    input  logic [DW-1:0] ld_wdata,
    output logic          ld_ack,
    input  logic          ld_lock,
    output logic [DW-1:0] rdata,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic          busy,
    output logic          grant_id
);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t        state_q, state_d;
    logic [1:0]    cnt_q, cnt_d;
    logic          last_q, last_d;
    logic          gid_q, gid_d;
    logic          we_q, we_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [DW-1:0] wdata_q, wdata_d;
    logic [DW-1:0] rdata_q, rdata_d;
    logic          mem_en_q, mem_en_d;
    logic          mem_we_q, mem_we_d;
    logic          cpu_ack_q, cpu_ack_d;
    logic          ld_ack_q, ld_ack_d;
    logic          busy_q, busy_d;
    logic          cpu_ok, pick;

    assign cpu_ok = cpu_req & ~ld_lock;
    // 1 selects the loader; on a tie the port that did not win last time goes
    assign pick   = (cpu_ok & ld_req) ? ~last_q : ld_req;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        last_d    = last_q;
        gid_d     = gid_q;
        we_d      = we_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        rdata_d   = rdata_q;
        mem_en_d  = 1'b0;
        mem_we_d  = 1'b0;
        cpu_ack_d = 1'b0;
        ld_ack_d  = 1'b0;
        case (state_q)
            IDLE: if (cpu_ok | ld_req) begin
                state_d  = ISSUE;
                gid_d    = pick;
                last_d   = pick;
                we_d     = pick ? ld_we : cpu_we;
                addr_d   = pick ? ld_addr : cpu_addr;
                wdata_d  = pick ? ld_wdata : cpu_wdata;
                mem_en_d = 1'b1;
                mem_we_d = we_d;
            end
            ISSUE: if (we_q) begin
                state_d   = RESP;
                cpu_ack_d = ~gid_q;
                ld_ack_d  = gid_q;
            end else begin
                state_d = WAIT;
                cnt_d   = 2'(RD_LAT);
            end
            WAIT: begin
                cnt_d = cnt_q - 2'd1;
                if (cnt_q == 2'd1) begin
                    state_d   = RESP;
                    rdata_d   = mem_rdata;
                    cpu_ack_d = ~gid_q;
                    ld_ack_d  = gid_q;
                end
            end
            RESP: state_d = IDLE;
        endcase
        busy_d = state_d != IDLE;
    end

    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            last_q    <= 1'b1;
            gid_q     <= 1'b0;
            we_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            rdata_q   <= '0;
            mem_en_q  <= 1'b0;
            mem_we_q  <= 1'b0;
            cpu_ack_q <= 1'b0;
            ld_ack_q  <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            last_q    <= last_d;
            gid_q     <= gid_d;
            we_q      <= we_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            rdata_q   <= rdata_d;
            mem_en_q  <= mem_en_d;
            mem_we_q  <= mem_we_d;
            cpu_ack_q <= cpu_ack_d;
            ld_ack_q  <= ld_ack_d;
            busy_q    <= busy_d;
        end
    end

    assign cpu_ack   = cpu_ack_q;
    assign ld_ack    = ld_ack_q;
    assign rdata     = rdata_q;
    assign mem_en    = mem_en_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign busy      = busy_q;
    assign grant_id  = gid_q;
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: drives RD_LAT=1 and RD_LAT=3 arbiters with shared stimulus and
// compares each against a transaction-timing reference model.
module tb_mem_arbiter;
    logic        CLK = 1'b0, Reset = 1'b0;
    logic        cpu_req = 1'b0, cpu_we = 1'b0, ld_req = 1'b0, ld_we = 1'b0, ld_lock = 1'b0;
    logic [15:0] cpu_addr = '0, cpu_wdata = '0, ld_addr = '0, ld_wdata = '0;
    logic [1:0]  cpu_ack, ld_ack, mem_en, mem_we, busy, grant_id;
    logic [15:0] mem_addr [2], mem_wdata [2], rdata [2];
    logic [15:0] mem_rdata [2] = '{16'h0, 16'h0};
    logic [15:0] emem [2][16] = '{default: 16'h0};

    int checks = 0, failures = 0, e = 0;
    int nxt [2] = '{0, 0}, st [2] = '{-1000, -1000}, le [2] = '{0, 0};
    bit lst [2] = '{1'b1, 1'b1}, prt [2], twe [2], in_rst [2];
    bit x_busy [2], x_en [2], x_ack [2];
    logic [15:0] taddr [2], twd [2], x_rd [2] = '{16'h0, 16'h0};
    logic [15:0] mm [2][16] = '{default: 16'h0};

    always #5 CLK = ~CLK;

    mem_arbiter #(.RD_LAT(1)) u_lat1 (
        .CLK(CLK), .Reset(Reset),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_ack(cpu_ack[0]),
        .ld_req(ld_req), .ld_we(ld_we), .ld_addr(ld_addr), .ld_wdata(ld_wdata), .ld_ack(ld_ack[0]),
        .ld_lock(ld_lock), .rdata(rdata[0]), .mem_en(mem_en[0]), .mem_we(mem_we[0]),
        .mem_addr(mem_addr[0]), .mem_wdata(mem_wdata[0]), .mem_rdata(mem_rdata[0]),
        .busy(busy[0]), .grant_id(grant_id[0])
    );

    mem_arbiter #(.RD_LAT(3)) u_lat3 (
        .CLK(CLK), .Reset(Reset),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_ack(cpu_ack[1]),
        .ld_req(ld_req), .ld_we(ld_we), .ld_addr(ld_addr), .ld_wdata(ld_wdata), .ld_ack(ld_ack[1]),
        .ld_lock(ld_lock), .rdata(rdata[1]), .mem_en(mem_en[1]), .mem_we(mem_we[1]),
        .mem_addr(mem_addr[1]), .mem_wdata(mem_wdata[1]), .mem_rdata(mem_rdata[1]),
        .busy(busy[1]), .grant_id(grant_id[1])
    );

    // Synchronous memory per instance, indexed by the low address nibble
    for (genvar g = 0; g < 2; g++) begin : g_mem
        always @(posedge CLK) begin
            if (mem_en[g]) begin
                if (mem_we[g]) emem[g][mem_addr[g][3:0]] <= mem_wdata[g];
                else mem_rdata[g] <= emem[g][mem_addr[g][3:0]];
            end
        end
    end

    // Grant at edge N: mem_en after N, ack after N+1+lat (lat=0 for writes), next grant from N+3+lat
    task automatic model(input int i, input int lat);
        bit p;
        if (!Reset) begin
            in_rst[i] = 1; lst[i] = 1; prt[i] = 0; twe[i] = 0; le[i] = 0;
            nxt[i] = e + 1; st[i] = -1000; x_rd[i] = 0; taddr[i] = 0; twd[i] = 0;
        end else begin
            in_rst[i] = 0;
            if (e >= nxt[i] && (ld_req || (cpu_req && !ld_lock))) begin
                p = (ld_req && cpu_req && !ld_lock) ? !lst[i] : ld_req;
                lst[i] = p; prt[i] = p;
                twe[i] = p ? ld_we : cpu_we;
                taddr[i] = p ? ld_addr : cpu_addr;
                twd[i] = p ? ld_wdata : cpu_wdata;
                le[i] = twe[i] ? 0 : lat;
                st[i] = e;
                nxt[i] = e + 3 + le[i];
            end
        end
        x_busy[i] = (e >= st[i]) && (e < nxt[i] - 1);
        x_en[i] = x_busy[i] && (e == st[i]);
        x_ack[i] = x_busy[i] && (e == st[i] + 1 + le[i]);
        if (x_ack[i] && !twe[i]) x_rd[i] = mm[i][taddr[i][3:0]];
        if (x_en[i] && twe[i]) mm[i][taddr[i][3:0]] = twd[i];
    endtask

    task automatic chk(input int i, input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s[lat%0d] edge=%0d observed=%h expected=%h", tag, i ? 3 : 1, e, obs, exp);
        end
    endtask

    task automatic verify(input int i);
        chk(i, "busy", 16'(busy[i]), 16'(x_busy[i]));
        chk(i, "mem_en", 16'(mem_en[i]), 16'(x_en[i]));
        chk(i, "mem_we", 16'(mem_we[i]), 16'(x_en[i] && twe[i]));
        chk(i, "cpu_ack", 16'(cpu_ack[i]), 16'(x_ack[i] && !prt[i]));
        chk(i, "ld_ack", 16'(ld_ack[i]), 16'(x_ack[i] && prt[i]));
        chk(i, "grant_id", 16'(grant_id[i]), 16'(prt[i]));
        chk(i, "rdata", rdata[i], x_rd[i]);
        if (x_en[i] || in_rst[i]) begin
            chk(i, "mem_addr", mem_addr[i], taddr[i]);
            chk(i, "mem_wdata", mem_wdata[i], twd[i]);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        e++;
        model(0, 1);
        model(1, 3);
        #1;
        verify(0);
        verify(1);
    endtask

    task automatic run(input int n);
        repeat (n) step();
    endtask

    initial begin
        run(3);
        Reset = 1'b1;
        ld_req = 1; ld_we = 1; ld_addr = 16'h0010; ld_wdata = 16'hBEEF;
        step(); ld_req = 0; run(4);
        ld_req = 1; ld_we = 1; ld_addr = 16'h0004; ld_wdata = 16'h1234;
        step(); ld_req = 0; run(4);
        cpu_req = 1; cpu_we = 0; cpu_addr = 16'h0010;
        run(3); cpu_req = 0; run(6);
        chk(0, "rdata_beef", rdata[0], 16'hBEEF);
        chk(1, "rdata_beef", rdata[1], 16'hBEEF);
        cpu_req = 1; cpu_we = 0; cpu_addr = 16'h0010;
        run(2); cpu_addr = 16'h0020; step(); cpu_req = 0; run(6);
        cpu_req = 1; cpu_we = 1; cpu_addr = 16'h0002; cpu_wdata = 16'h5A5A;
        ld_req = 1; ld_we = 0; ld_addr = 16'h0004;
        run(24); cpu_req = 0; ld_req = 0; run(6);
        ld_lock = 1; cpu_req = 1; cpu_we = 0; cpu_addr = 16'h0002; ld_req = 1; ld_we = 1; ld_addr = 16'h0007;
        run(16); ld_lock = 0; run(12); cpu_req = 0; ld_req = 0; run(6);
        cpu_req = 1; cpu_we = 0; cpu_addr = 16'h0004;
        step(); cpu_req = 0; run(2);
        Reset = 1'b0;
        #1;
        chk(1, "rst_async_mem_en", 16'(mem_en[1]), 16'h0);
        chk(1, "rst_async_busy", 16'(busy[1]), 16'h0);
        chk(1, "rst_async_cpu_ack", 16'(cpu_ack[1]), 16'h0);
        run(2); Reset = 1'b1;
        cpu_req = 1; cpu_we = 0; cpu_addr = 16'h0004;
        step(); cpu_req = 0; run(8);
        repeat (400) begin
            cpu_req = $urandom_range(0, 3) != 0;
            cpu_we = $urandom_range(0, 1) == 1;
            cpu_addr = 16'($urandom_range(0, 31));
            cpu_wdata = 16'($urandom);
            ld_req = $urandom_range(0, 2) == 0;
            ld_we = $urandom_range(0, 1) == 1;
            ld_addr = 16'($urandom_range(0, 31));
            ld_wdata = 16'($urandom);
            ld_lock = $urandom_range(0, 7) == 0;
            step();
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
